// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_pkg;

  // Sweep FSM: clear every entry after reset, then serve the core.
  typedef enum logic {
    StClear,
    StRun
  } state_e;

  // Hardwired-zero register index.
  localparam int unsigned ZERO_REG = 0;

  // Fixed destination indices used by the control unit's destination mux.
  localparam int unsigned XP = 1;

  // Return-address register is the last entry, so it depends on the depth.
  function automatic int unsigned ra_idx(input int unsigned depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file access bundle: read ports, commit write, reserve and long writeback.
interface regfile_sb_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
);

  logic             ready;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic [WIDTH-1:0] radata;
  logic [WIDTH-1:0] rbdata;
  logic             ra_busy;
  logic             rb_busy;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             resv_valid;
  logic [AW-1:0]    resv_addr;
  logic             lwb_valid;
  logic [AW-1:0]    lwb_addr;
  logic [WIDTH-1:0] lwb_data;
  logic             waw_err;

  // Core side: issues reads, writes and reservations.
  modport master (
    output ra, rb, we, waddr, wdata, resv_valid, resv_addr, lwb_valid, lwb_addr, lwb_data,
    input  ready, radata, rbdata, ra_busy, rb_busy, waw_err
  );

  // Register-file side.
  modport slave (
    input  ra, rb, we, waddr, wdata, resv_valid, resv_addr, lwb_valid, lwb_addr, lwb_data,
    output ready, radata, rbdata, ra_busy, rb_busy, waw_err
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for destinations owned by in-flight long operations.
// Enables arrive pre-qualified (RUN state, non-zero address) from the top.
module regfile_scoreboard #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rd_a,
  input  logic [AW-1:0] rd_b,
  output logic          busy_a,
  output logic          busy_b,
  output logic          waw_err
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic             wr_hazard, set_hazard;

  // Next busy vector and sticky error; a same-cycle writeback releases the entry first.
  always_comb begin
    busy_d     = busy_q;
    wr_hazard  = wr_en && busy_q[wr_addr] && !(clr_en && (clr_addr == wr_addr));
    set_hazard = set_en && busy_q[set_addr] && !(clr_en && (clr_addr == set_addr));
    err_d      = err_q || wr_hazard || set_hazard;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    // Set after clear so reserve + writeback to one register leaves it busy.
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy and error state, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Lookups for the two read ports.
  always_comb begin
    busy_a  = busy_q[rd_a];
    busy_b  = busy_q[rd_b];
    waw_err = err_q;
  end

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded register file: two combinational reads, commit write, long writeback.
// The array is zeroed by a post-reset sweep (CLEAR) instead of a wide reset.
// Optional build macro REGFILE_BYPASS_EN enables same-cycle read forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  localparam logic [AW-1:0] Zero = AW'(ZERO_REG);
  localparam logic [AW-1:0] Last = AW'(DEPTH - 1);

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic             ready_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             run;
  logic             we_en, resv_en, lwb_en;
  logic             sb_busy_a, sb_busy_b, sb_err;
  logic [WIDTH-1:0] radata_c, rbdata_c;
  logic             ra_busy_c, rb_busy_c;

  // Request qualification: ports are ignored during the sweep and for register 0.
  always_comb begin
    run     = (state_q == StRun);
    we_en   = run && bus.we && (bus.waddr != Zero);
    resv_en = run && bus.resv_valid && (bus.resv_addr != Zero);
    lwb_en  = run && bus.lwb_valid && (bus.lwb_addr != Zero);
  end

  // Sweep FSM with registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClear;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        StClear: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == Last) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array writes: sweep zeroing, then writeback and commit (commit lands last and wins).
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StClear) begin
        mem_q[cnt_q] <= '0;
      end else begin
        if (lwb_en) mem_q[bus.lwb_addr] <= bus.lwb_data;
        if (we_en)  mem_q[bus.waddr]    <= bus.wdata;
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (resv_en),
    .set_addr (bus.resv_addr),
    .clr_en   (lwb_en),
    .clr_addr (bus.lwb_addr),
    .wr_en    (we_en),
    .wr_addr  (bus.waddr),
    .rd_a     (bus.ra),
    .rd_b     (bus.rb),
    .busy_a   (sb_busy_a),
    .busy_b   (sb_busy_b),
    .waw_err  (sb_err)
  );

  // Read port A: zero in CLEAR and for register 0, optional forwarding.
  always_comb begin
    radata_c  = '0;
    ra_busy_c = 1'b0;
    if (run && (bus.ra != Zero)) begin
`ifdef REGFILE_BYPASS_EN
      if (we_en && (bus.waddr == bus.ra))          radata_c = bus.wdata;
      else if (lwb_en && (bus.lwb_addr == bus.ra)) radata_c = bus.lwb_data;
      else                                         radata_c = mem_q[bus.ra];
      ra_busy_c = sb_busy_a && !(lwb_en && (bus.lwb_addr == bus.ra));
`else
      radata_c  = mem_q[bus.ra];
      ra_busy_c = sb_busy_a;
`endif
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    rbdata_c  = '0;
    rb_busy_c = 1'b0;
    if (run && (bus.rb != Zero)) begin
`ifdef REGFILE_BYPASS_EN
      if (we_en && (bus.waddr == bus.rb))          rbdata_c = bus.wdata;
      else if (lwb_en && (bus.lwb_addr == bus.rb)) rbdata_c = bus.lwb_data;
      else                                         rbdata_c = mem_q[bus.rb];
      rb_busy_c = sb_busy_b && !(lwb_en && (bus.lwb_addr == bus.rb));
`else
      rbdata_c  = mem_q[bus.rb];
      rb_busy_c = sb_busy_b;
`endif
    end
  end

  assign bus.ready   = ready_q;
  assign bus.radata  = radata_c;
  assign bus.rbdata  = rbdata_c;
  assign bus.ra_busy = ra_busy_c;
  assign bus.rb_busy = rb_busy_c;
  assign bus.waw_err = sb_err;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, scoreboarded register file for the MIPS core: two combinational read ports, one single-cycle commit write port and one long-latency writeback port (multiply/divide unit). A per-register busy bit tracks destinations reserved by in-flight long operations so the control unit can stall on RAW hazards. Register 0 is hardwired to zero, and the array is cleared by a post-reset sweep instead of a wide reset.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers (power of two, ≥ 2)
- AW, $clog2(DEPTH), address width (derived; not overridden)

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- ready  out  1  high once the clear sweep is complete
- ra, rb  in  AW  read addresses
- radata, rbdata  out  WIDTH  read data
- ra_busy, rb_busy  out  1  addressed register awaits long-latency writeback
- we  in  1  commit write enable
- waddr  in  AW  commit write address
- wdata  in  WIDTH  commit write data
- resv_valid  in  1  reserve a destination for a long operation
- resv_addr  in  AW  register to reserve
- lwb_valid  in  1  long-latency writeback valid
- lwb_addr  in  AW  writeback address
- lwb_data  in  WIDTH  writeback data
- waw_err  out  1  sticky protocol-error flag

## Operation
- FSM states: CLEAR, RUN. Reset sampled high gives CLEAR, sweep counter 0, all busy bits 0, waw_err 0, ready 0.
- CLEAR: each cycle with reset low writes 0 to entry cnt, then cnt+1. After entry DEPTH-1 is written, next state is RUN.
- During CLEAR: we, resv_valid and lwb_valid are ignored; radata/rbdata read 0; busy outputs read 0.
- RUN, reads: radata = registers[ra], rbdata = registers[rb]. Address 0 always reads 0 and is never busy.
- Commit: we with waddr≠0 writes wdata at the edge.
- Reserve: resv_valid with resv_addr≠0 sets busy[resv_addr].
- Long writeback: lwb_valid with lwb_addr≠0 writes lwb_data and clears busy[lwb_addr].
- Simultaneous we and lwb to the same address: the commit data wins, and busy is still cleared.
- Simultaneous resv and lwb to the same address: the data is written and busy stays set.
- waw_err sets, and holds until reset, on either of:
  - we to a register that is busy and not cleared by lwb in the same cycle
  - resv to a register that is already busy and not cleared by lwb in the same cycle
- lwb to a non-busy register is legal: the data is written and no error is raised.
- Writes or reservations to address 0 are silently dropped.

## Timing
- Reads are combinational (zero latency). Writes and busy updates are visible the cycle after the edge.
- ready rises DEPTH cycles after the first rising edge with reset low.
- Reset asserted mid-sweep or in RUN restarts the sweep from entry 0 on the next edge.
- No handshake back-pressure: each port is valid-only, and every port accepts one request per cycle.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle forwarding.
  - A read matching an active write returns the incoming data, with lwb_data taking precedence below wdata per the collision rule.
  - ra_busy/rb_busy are masked when lwb_valid targets the same address that cycle.
- REGFILE_BYPASS_EN undefined: reads return the pre-edge array value, and busy reflects the registered bit only.
- Address 0 and CLEAR masking apply in both builds.

## Structure
- regfile_pkg holds:
  - the state enum typedef (CLEAR, RUN)
  - ZERO_REG constant
  - special indices XP = 1 and RA = DEPTH-1 for the control unit's destination mux
- Sub-module regfile_scoreboard: DEPTH-bit busy vector with set/clear ports, waw_err generation and busy lookups for ra/rb. The array, sweep FSM and bypass muxing stay in regfile_sb.

## Test plan
- Reset, then idle DEPTH=32 → ready low for 32 cycles, high on cycle 32; all reads return 0 during the sweep.
- RUN: we, waddr=5, wdata=0xDEADBEEF; then ra=5 → radata 0xDEADBEEF next cycle. Same-cycle read returns it only with REGFILE_BYPASS_EN.
- we to waddr=0 with 0x1234 → radata for ra=0 stays 0; resv to 0 → ra_busy stays 0.
- resv_addr=9, then ra=9 → ra_busy=1. Three cycles later lwb_addr=9, lwb_data=0x55 → busy clears and radata=0x55; waw_err stays 0.
- resv_addr=9, then we, waddr=9 one cycle later → waw_err=1 and stays 1 until reset.
- Reset asserted mid-sweep at cnt=10 → sweep restarts; ready rises 32 cycles after reset deasserts.
